// File: rtl/tile_map_writer_pkg.sv
// tile_map_writer_pkg
//   Shared definitions for the tile-map port-A writer and the VGA scan-out:
//   map geometry defaults, host opcodes, the writer FSM state encoding and
//   the (col,row) -> linear address helper.
package tile_map_writer_pkg;

  localparam int unsigned MAP_COLS_DEF = 80;
  localparam int unsigned MAP_ROWS_DEF = 60;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_FILL    = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_CAP  = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  // Row-major linear tile index. Callers truncate to their address width.
  function automatic int unsigned tile_lin(input int unsigned col,
                                           input int unsigned row,
                                           input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/tile_map_writer_if.sv
// tile_map_writer_if
//   Host-side command and response channels of the tile-map writer.
//   master : host issuing commands and consuming responses
//   slave  : the tile_map_writer
//   cmd_valid/cmd_ready : command handshake; cmd_op/cmd_col/cmd_row/cmd_data payload
//   rsp_valid/rsp_ready : read response handshake; rsp_data payload
interface tile_map_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_WIDTH  = 7,
  parameter int ROW_WIDTH  = 6
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [COL_WIDTH-1:0]  cmd_col;
  logic [ROW_WIDTH-1:0]  cmd_row;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_col, cmd_row, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tile_map_writer.sv
// tile_map_writer
//   Port-A agent of the shared tile/glyph dual-port BRAM. Executes host
//   cell-write, whole-map fill and cell-read commands; port B belongs to
//   the VGA scan-out and is not touched here.
// Ports
//   clk    : system clock, shared with the BRAM
//   reset  : synchronous, active-high
//   host   : command / response channels (tile_map_writer_if.slave)
//   busy   : high whenever the FSM is not idle
//   err    : one-cycle pulse when an out-of-range or reserved command is dropped
//   q_a    : BRAM port-A read data, valid the cycle after addr_a
//   addr_a, data_a, we_a : BRAM port-A address / write data / write enable
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a command
// ST_WR      | single-cell write on port A (we_a high this cycle)
// ST_FILL    | one write per cycle over the whole map
// ST_RD_ADDR | read address presented on port A
// ST_RD_CAP  | BRAM output valid, captured into rsp_data
// ST_RSP     | response held until the host takes it
module tile_map_writer
  import tile_map_writer_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 16,
  parameter int unsigned MAP_COLS   = MAP_COLS_DEF,
  parameter int unsigned MAP_ROWS   = MAP_ROWS_DEF,
  parameter int          COL_WIDTH  = 7,
  parameter int          ROW_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  tile_map_writer_if.slave      host,
  output logic                  busy,
  output logic                  err,
  input  logic [DATA_WIDTH-1:0] q_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_a
);

  localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(MAP_COLS * MAP_ROWS - 1);

  state_e                  state_q, state_d;
  logic                    in_reset_q;
  logic [ADDR_WIDTH-1:0]   fill_left_q, fill_left_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
  logic [DATA_WIDTH-1:0]   data_a_q, data_a_d;
  logic                    we_a_q, we_a_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    cmd_bad;
  logic                    cmd_ok;
  logic [ADDR_WIDTH-1:0]   cmd_lin;

  // in_reset_q keeps cmd_ready low while reset is applied even though the
  // state register already reads IDLE; it stays a pure register decode.
  assign host.cmd_ready = (state_q == ST_IDLE) && !in_reset_q;
  assign accept         = host.cmd_valid && host.cmd_ready;

  // FILL ignores col/row, so only WRITE/READ are bounds-checked.
  always_comb begin
    cmd_bad = 1'b0;
    if (host.cmd_op == OP_RSVD) begin
      cmd_bad = 1'b1;
    end else if (host.cmd_op != OP_FILL) begin
      cmd_bad = (32'(host.cmd_col) >= MAP_COLS) || (32'(host.cmd_row) >= MAP_ROWS);
    end
  end

  assign cmd_ok  = accept && !cmd_bad;
  assign cmd_lin = ADDR_WIDTH'(tile_lin(32'(host.cmd_col), 32'(host.cmd_row), MAP_COLS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_reset_q  <= 1'b1;
      fill_left_q <= '0;
      addr_a_q    <= '0;
      data_a_q    <= '0;
      we_a_q      <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_reset_q  <= 1'b0;
      fill_left_q <= fill_left_d;
      addr_a_q    <= addr_a_d;
      data_a_q    <= data_a_d;
      we_a_q      <= we_a_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_ok) begin
          case (host.cmd_op)
            OP_WRITE: state_d = ST_WR;
            OP_FILL:  state_d = ST_FILL;
            OP_READ:  state_d = ST_RD_ADDR;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_FILL:    if (fill_left_q == '0) state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP:  state_d = ST_RSP;
      ST_RSP:     if (host.rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so each _d describes what the port shows in the
  // state being entered. addr_a/data_a hold unless a new access loads them.
  always_comb begin
    fill_left_d = fill_left_q;
    addr_a_d    = addr_a_q;
    data_a_d    = data_a_q;
    we_a_d      = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = accept && cmd_bad;
    case (state_q)
      ST_IDLE: begin
        if (cmd_ok) begin
          case (host.cmd_op)
            OP_WRITE: begin
              we_a_d   = 1'b1;
              addr_a_d = cmd_lin;
              data_a_d = host.cmd_data;
            end
            OP_FILL: begin
              we_a_d      = 1'b1;
              addr_a_d    = '0;
              data_a_d    = host.cmd_data;
              fill_left_d = FILL_LAST;
            end
            OP_READ: begin
              addr_a_d = cmd_lin;
            end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        // fill_left_q counts writes still to come after the current one.
        if (fill_left_q != '0) begin
          we_a_d      = 1'b1;
          addr_a_d    = addr_a_q + 1'b1;
          fill_left_d = fill_left_q - 1'b1;
        end
      end
      ST_RD_CAP: rsp_data_d = q_a;
      default: ;
    endcase
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
  end

  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign addr_a         = addr_a_q;
  assign data_a         = data_a_q;
  assign we_a           = we_a_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// tb_tile_map_writer
//   Directed bench for tile_map_writer with a behavioural port-A BRAM
//   (read-first, registered q_a) and a write monitor.
module tb_tile_map_writer;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int CELLS = 4800;

  logic          clk;
  logic          reset;
  logic          busy;
  logic          err;
  logic [DW-1:0] q_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          we_a;

  tile_map_writer_if #(.DATA_WIDTH(DW), .COL_WIDTH(7), .ROW_WIDTH(6)) hif ();

  tile_map_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAP_COLS(80), .MAP_ROWS(60),
    .COL_WIDTH(7), .ROW_WIDTH(6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .host   (hif),
    .busy   (busy),
    .err    (err),
    .q_a    (q_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .we_a   (we_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model; mem_load preloads a known pattern 16'h1000 + index.
  logic [DW-1:0] mem [0:CELLS-1];
  logic          mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= DW'(16'h1000 + i);
    end else if (we_a && int'(addr_a) < CELLS) begin
      mem[int'(addr_a)] <= data_a;
    end
    q_a <= (int'(addr_a) < CELLS) ? mem[int'(addr_a)] : '0;
  end

  // Write monitor: counts we_a cycles and checks the addresses are consecutive from 0.
  logic          mon_clr;
  int            wr_cnt;
  int            addr_err;
  logic [AW-1:0] mon_addr;
  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt   <= 0;
      addr_err <= 0;
      mon_addr <= '0;
    end else if (we_a) begin
      wr_cnt   <= wr_cnt + 1;
      mon_addr <= mon_addr + 1'b1;
      if (addr_a != mon_addr) addr_err <= addr_err + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input int col, input int row, input logic [DW-1:0] d);
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    hif.cmd_col   = 7'(col);
    hif.cmd_row   = 6'(row);
    hif.cmd_data  = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(hif.cmd_ready), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_err"},       32'(err), 0);
    check({tag, "_we_a"},      32'(we_a), 0);
    check({tag, "_addr_a"},    32'(addr_a), 0);
    check({tag, "_data_a"},    32'(data_a), 0);
    check({tag, "_rsp_valid"}, 32'(hif.rsp_valid), 0);
    check({tag, "_rsp_data"},  32'(hif.rsp_data), 0);
  endtask

  initial begin
    int cnt;
    int guard;
    reset         = 1'b1;
    mem_load      = 1'b1;
    mon_clr       = 1'b1;
    hif.cmd_valid = 1'b0;
    hif.cmd_op    = 2'b00;
    hif.cmd_col   = '0;
    hif.cmd_row   = '0;
    hif.cmd_data  = '0;
    hif.rsp_ready = 1'b0;
    tick;
    tick;
    mem_load = 1'b0;
    check_all_zero("reset");
    reset   = 1'b0;
    mon_clr = 1'b0;
    tick;
    check("ready_after_reset", 32'(hif.cmd_ready), 1);

    // WRITE col=5,row=2 -> addr 165
    drive_cmd(2'b00, 5, 2, 16'hA5A5);
    tick;
    hif.cmd_valid = 1'b0;
    check("wr_we", 32'(we_a), 1);
    check("wr_addr", 32'(addr_a), 165);
    check("wr_data", 32'(data_a), 16'hA5A5);
    check("wr_ready_low", 32'(hif.cmd_ready), 0);
    check("wr_busy", 32'(busy), 1);
    tick;
    check("wr_we_end", 32'(we_a), 0);
    check("wr_ready_back", 32'(hif.cmd_ready), 1);
    check("wr_addr_hold", 32'(addr_a), 165);
    check("wr_mem", 32'(mem[165]), 16'hA5A5);

    // READ back with rsp_ready low for 3 cycles
    drive_cmd(2'b10, 5, 2, 16'h0000);
    tick;
    hif.cmd_valid = 1'b0;
    check("rd_addr", 32'(addr_a), 165);
    check("rd_no_we", 32'(we_a), 0);
    check("rd_valid_c1", 32'(hif.rsp_valid), 0);
    tick;
    check("rd_valid_c2", 32'(hif.rsp_valid), 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      check("rd_valid_hold", 32'(hif.rsp_valid), 1);
      check("rd_data_hold", 32'(hif.rsp_data), 16'hA5A5);
      check("rd_ready_low", 32'(hif.cmd_ready), 0);
      if (i < 2) tick;
    end
    hif.rsp_ready = 1'b1;
    tick;
    check("rd_valid_drop", 32'(hif.rsp_valid), 0);
    check("rd_idle", 32'(hif.cmd_ready), 1);

    // READ col=0,row=0 with rsp_ready already high -> one-cycle rsp_valid
    drive_cmd(2'b10, 0, 0, 16'h0000);
    tick;
    hif.cmd_valid = 1'b0;
    tick;
    tick;
    check("rd2_valid", 32'(hif.rsp_valid), 1);
    check("rd2_data", 32'(hif.rsp_data), 16'h1000);
    tick;
    check("rd2_valid_1cyc", 32'(hif.rsp_valid), 0);
    hif.rsp_ready = 1'b0;

    // Range / reserved commands
    mon_clr = 1'b1;
    tick;
    mon_clr = 1'b0;
    drive_cmd(2'b00, 80, 0, 16'hDEAD);
    tick;
    hif.cmd_valid = 1'b0;
    check("oob_col_err", 32'(err), 1);
    check("oob_col_busy", 32'(busy), 0);
    check("oob_col_ready", 32'(hif.cmd_ready), 1);
    tick;
    check("oob_col_err_pulse", 32'(err), 0);
    drive_cmd(2'b11, 1, 1, 16'hBEEF);
    tick;
    hif.cmd_valid = 1'b0;
    check("rsvd_err", 32'(err), 1);
    tick;
    check("rsvd_err_pulse", 32'(err), 0);
    drive_cmd(2'b10, 0, 60, 16'h0000);
    tick;
    hif.cmd_valid = 1'b0;
    check("oob_row_err", 32'(err), 1);
    tick;
    tick;
    tick;
    check("oob_row_no_rsp", 32'(hif.rsp_valid), 0);
    check("oob_no_writes", 32'(wr_cnt), 0);
    check("oob_mem80", 32'(mem[80]), 16'h1050);
    check("oob_mem81", 32'(mem[81]), 16'h1051);

    // Back-to-back WRITEs with cmd_valid held high
    drive_cmd(2'b00, 1, 0, 16'h1111);
    tick;
    check("b2b_w0_we", 32'(we_a), 1);
    check("b2b_w0_addr", 32'(addr_a), 1);
    check("b2b_w0_ready", 32'(hif.cmd_ready), 0);
    drive_cmd(2'b00, 2, 0, 16'h2222);
    tick;
    check("b2b_gap0_we", 32'(we_a), 0);
    tick;
    check("b2b_w1_we", 32'(we_a), 1);
    check("b2b_w1_addr", 32'(addr_a), 2);
    drive_cmd(2'b00, 0, 1, 16'h3333);
    tick;
    check("b2b_gap1_we", 32'(we_a), 0);
    tick;
    hif.cmd_valid = 1'b0;
    check("b2b_w2_we", 32'(we_a), 1);
    check("b2b_w2_addr", 32'(addr_a), 80);
    check("b2b_w2_data", 32'(data_a), 16'h3333);
    tick;
    check("b2b_mem1", 32'(mem[1]), 16'h1111);
    check("b2b_mem2", 32'(mem[2]), 16'h2222);
    check("b2b_mem80", 32'(mem[80]), 16'h3333);

    // FILL (col/row out of range but ignored)
    mon_clr = 1'b1;
    tick;
    mon_clr = 1'b0;
    drive_cmd(2'b01, 127, 63, 16'h0020);
    tick;
    hif.cmd_valid = 1'b0;
    check("fill_err", 32'(err), 0);
    check("fill_first_addr", 32'(addr_a), 0);
    cnt   = 0;
    guard = 0;
    while (busy && guard < 6000) begin
      cnt++;
      guard++;
      tick;
    end
    check("fill_timeout", 32'(guard < 6000), 1);
    check("fill_busy_cycles", 32'(cnt), CELLS);
    check("fill_we_cycles", 32'(wr_cnt), CELLS);
    check("fill_addr_seq", 32'(addr_err), 0);
    check("fill_mem0", 32'(mem[0]), 16'h0020);
    check("fill_mem_last", 32'(mem[4799]), 16'h0020);
    drive_cmd(2'b10, 79, 59, 16'h0000);
    tick;
    hif.cmd_valid = 1'b0;
    hif.rsp_ready = 1'b1;
    tick;
    tick;
    check("fill_rd_valid", 32'(hif.rsp_valid), 1);
    check("fill_rd_data", 32'(hif.rsp_data), 16'h0020);
    tick;
    hif.rsp_ready = 1'b0;

    // Reset mid-fill: reset sampled on the edge that commits address 999
    drive_cmd(2'b01, 0, 0, 16'h0BAD);
    tick;
    hif.cmd_valid = 1'b0;
    guard = 0;
    while (!(we_a && addr_a == 16'd999) && guard < 2000) begin
      guard++;
      tick;
    end
    check("mid_fill_reach", 32'(guard < 2000), 1);
    reset = 1'b1;
    tick;
    check_all_zero("mid_fill_reset");
    mon_clr = 1'b1;
    reset   = 1'b0;
    tick;
    mon_clr = 1'b0;
    check("mid_fill_ready", 32'(hif.cmd_ready), 1);
    tick;
    tick;
    check("mid_fill_no_we", 32'(wr_cnt), 0);
    check("mid_fill_mem999", 32'(mem[999]), 16'h0BAD);
    check("mid_fill_mem1000", 32'(mem[1000]), 16'h0020);
    check("mid_fill_mem4799", 32'(mem[4799]), 16'h0020);

    // Reset mid-read: no response afterwards
    drive_cmd(2'b10, 5, 2, 16'h0000);
    tick;
    hif.cmd_valid = 1'b0;
    reset = 1'b1;
    tick;
    check("mid_rd_busy", 32'(busy), 0);
    reset = 1'b0;
    tick;
    tick;
    tick;
    check("mid_rd_no_rsp", 32'(hif.rsp_valid), 0);
    check("mid_rd_ready", 32'(hif.cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
